// File: rtl/rr_mux4to1.sv
// Four-way round-robin merge of valid/ready channels into one registered stream.
// Each output word is tagged with the index of the channel that supplied it.
module rr_mux4to1 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
);

   logic [1:0]       ptr_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   logic [1:0]       out_sel_r;

   logic [3:0]       rot_valid_s;
   logic [1:0]       grant_off_s;
   logic             grant_found_s;
   logic [1:0]       grant_idx_s;
   logic [3:0]       grant_onehot_s;
   logic             slot_free_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [WIDTH-1:0] grant_data_s;

   // Rotate valids so bit j is channel (ptr + j) mod 4, then priority-encode.
   always_comb begin
      rot_valid_s   = in_valid;
      grant_off_s   = 2'd0;
      grant_found_s = 1'b0;
      case (ptr_r)
         2'd0:    rot_valid_s = in_valid;
         2'd1:    rot_valid_s = {in_valid[0],   in_valid[3:1]};
         2'd2:    rot_valid_s = {in_valid[1:0], in_valid[3:2]};
         2'd3:    rot_valid_s = {in_valid[2:0], in_valid[3]};
         default: rot_valid_s = in_valid;
      endcase
      casez (rot_valid_s)
         4'b???1: begin grant_off_s = 2'd0; grant_found_s = 1'b1; end
         4'b??10: begin grant_off_s = 2'd1; grant_found_s = 1'b1; end
         4'b?100: begin grant_off_s = 2'd2; grant_found_s = 1'b1; end
         4'b1000: begin grant_off_s = 2'd3; grant_found_s = 1'b1; end
         default: begin grant_off_s = 2'd0; grant_found_s = 1'b0; end
      endcase
   end

   // Translate the rotated offset back to a channel index and select its data.
   always_comb begin
      grant_idx_s    = ptr_r + grant_off_s;
      grant_onehot_s = 4'b0000;
      grant_data_s   = in_data[WIDTH-1:0];
      case (grant_idx_s)
         2'd0: begin grant_onehot_s = 4'b0001; grant_data_s = in_data[0*WIDTH +: WIDTH]; end
         2'd1: begin grant_onehot_s = 4'b0010; grant_data_s = in_data[1*WIDTH +: WIDTH]; end
         2'd2: begin grant_onehot_s = 4'b0100; grant_data_s = in_data[2*WIDTH +: WIDTH]; end
         2'd3: begin grant_onehot_s = 4'b1000; grant_data_s = in_data[3*WIDTH +: WIDTH]; end
         default: begin grant_onehot_s = 4'b0000; grant_data_s = in_data[WIDTH-1:0]; end
      endcase
   end

   // Handshake qualification; rst_n gates in_ready so nothing is accepted in reset.
   always_comb begin
      slot_free_s = ~out_valid_r | out_ready;
      out_xfer_s  = out_valid_r & out_ready;
      if (rst_n && slot_free_s && grant_found_s) begin
         in_ready  = grant_onehot_s;
         in_xfer_s = 1'b1;
      end else begin
         in_ready  = 4'b0000;
         in_xfer_s = 1'b0;
      end
   end

   // Output word register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_sel_r   <= 2'd0;
         ptr_r       <= 2'd0;
      end else if (in_xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= grant_data_s;
         out_sel_r   <= grant_idx_s;
         ptr_r       <= grant_idx_s + 2'd1;
      end else if (out_xfer_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_sel   = out_sel_r;

   rr_mux4to1_chk #(.WIDTH(WIDTH)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

endmodule

// Protocol properties of the merge: single grant, grant only to a requester,
// and a stalled output word held unchanged.
module rr_mux4to1_chk #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   input logic [3:0]       in_valid,
   input logic [3:0]       in_ready,
   input logic             out_valid,
   input logic [WIDTH-1:0] out_data,
   input logic [1:0]       out_sel,
   input logic             out_ready
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(in_ready));

   a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
      ((in_ready & ~in_valid) == 4'b0000));

   a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule
